// File: rtl/seq_generator_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_generator_if
//  Brief    : Request/serial-output bundle between a pattern source and
//             seq_generator.
//  Revision : 1.0 - initial release
// ============================================================================
interface seq_generator_if #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
);
  localparam int LEN_W = $clog2(WIDTH + 1);

  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [REP_W-1:0] reps;
  logic             en;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, len, reps, en,
    input  dout, dout_valid, busy, done
  );

  modport slave (
    input  start, pattern, len, reps, en,
    output dout, dout_valid, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/seq_generator.sv
`default_nettype none
// ============================================================================
//  Module   : seq_generator
//  Brief    : Serial MSB-first pattern generator with repeat count.
//             Define SEQ_GEN_GAP_EN to insert one dead cycle between passes.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_generator #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  seq_generator_if.slave bus
);
  localparam int LEN_W = $clog2(WIDTH + 1);
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [LEN_W-1:0] c_max_len = LEN_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
`ifdef SEQ_GEN_GAP_EN
    , S_GAP = 2'd3
`endif
  } state_t;

  state_t           r_state,  w_state_nxt;
  logic [WIDTH-1:0] r_shreg,  w_shreg_nxt;
  logic [IDX_W-1:0] r_last,   w_last_nxt;
  logic [IDX_W-1:0] r_bitcnt, w_bitcnt_nxt;
  logic [REP_W-1:0] r_repcnt, w_repcnt_nxt;

  logic [LEN_W-1:0] w_len_clamp;
  logic [IDX_W-1:0] w_len_m1;
  logic             w_dout;
  logic             w_dout_valid;
  logic             w_busy;
  logic             w_done;

  assign w_len_clamp = (bus.len > c_max_len) ? c_max_len : bus.len;
  // Only meaningful for a non-zero length; the zero case never enters SHIFT.
  assign w_len_m1    = IDX_W'(w_len_clamp - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_shreg  <= '0;
      r_last   <= '0;
      r_bitcnt <= '0;
      r_repcnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_shreg  <= w_shreg_nxt;
      r_last   <= w_last_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_repcnt <= w_repcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_last_nxt   = r_last;
    w_bitcnt_nxt = r_bitcnt;
    w_repcnt_nxt = r_repcnt;
    w_dout       = 1'b0;
    w_dout_valid = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_shreg_nxt  = bus.pattern;
          w_last_nxt   = w_len_m1;
          w_bitcnt_nxt = w_len_m1;
          w_repcnt_nxt = bus.reps;
          w_state_nxt  = (w_len_clamp == '0) ? S_DONE : S_SHIFT;
        end
      end

      S_SHIFT: begin
        w_dout       = r_shreg[r_bitcnt];
        w_dout_valid = bus.en;
        w_busy       = 1'b1;
        if (bus.en) begin
          if (r_bitcnt != '0) begin
            w_bitcnt_nxt = r_bitcnt - 1'b1;
          end else if (r_repcnt != '0) begin
            w_repcnt_nxt = r_repcnt - 1'b1;
            w_bitcnt_nxt = r_last;
`ifdef SEQ_GEN_GAP_EN
            w_state_nxt  = S_GAP;
`endif
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end

`ifdef SEQ_GEN_GAP_EN
      S_GAP: begin
        w_busy = 1'b1;
        if (bus.en) begin
          w_state_nxt = S_SHIFT;
        end
      end
`endif

      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.dout       = w_dout;
  assign bus.dout_valid = w_dout_valid;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_generator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_generator
//  Brief    : Self-checking bench for seq_generator against an expected
//             bit-stream queue built from the transfer parameters.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_generator;
  localparam int WIDTH = 8;
  localparam int REP_W = 4;
  localparam int GAP_ITEM = 2;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  seq_generator_if #(.WIDTH(WIDTH), .REP_W(REP_W)) bus ();

  seq_generator #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_outs(input string tag, input logic d, input logic v, input logic b, input logic dn);
    check({tag, ".dout"},       {31'd0, bus.dout},       {31'd0, d});
    check({tag, ".dout_valid"}, {31'd0, bus.dout_valid}, {31'd0, v});
    check({tag, ".busy"},       {31'd0, bus.busy},       {31'd0, b});
    check({tag, ".done"},       {31'd0, bus.done},       {31'd0, dn});
  endtask

  // One transfer. stall_at forces en=0 in that cycle after start (0 = first bit cycle).
  task automatic run_xfer(input logic [7:0] pat, input logic [3:0] l, input logic [3:0] r,
                          input int en_pct, input int stall_at);
    int  q[$];
    int  eff;
    bit  finished;
    eff = (l > WIDTH) ? WIDTH : int'(l);
    if (eff > 0) begin
      for (int p = 0; p <= int'(r); p++) begin
`ifdef SEQ_GEN_GAP_EN
        if (p > 0) q.push_back(GAP_ITEM);
`endif
        for (int i = eff - 1; i >= 0; i--) q.push_back(int'(pat[i]));
      end
    end

    @(negedge clk);
    bus.start   = 1'b1;
    bus.pattern = pat;
    bus.len     = l;
    bus.reps    = r;
    bus.en      = 1'($urandom);
    #1;
    check_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    finished = 1'b0;
    for (int c = 0; c < 2000 && !finished; c++) begin
      @(negedge clk);
      // Junk on the request side must be ignored while a transfer is active.
      bus.start   = 1'($urandom);
      bus.pattern = 8'($urandom);
      bus.len     = 4'($urandom);
      bus.reps    = 4'($urandom);
      bus.en      = (c == stall_at) ? 1'b0 : ($urandom_range(0, 99) < en_pct);
      #1;
      if (q.size() == 0) begin
        check_outs("done", 1'b0, 1'b0, 1'b0, 1'b1);
        finished = 1'b1;
      end else if (q[0] == GAP_ITEM) begin
        check_outs("gap", 1'b0, 1'b0, 1'b1, 1'b0);
        if (bus.en) void'(q.pop_front());
      end else begin
        check_outs("bit", 1'(q[0]), bus.en, 1'b1, 1'b0);
        if (bus.en) void'(q.pop_front());
      end
    end
    bus.start = 1'b0;
    if (!finished) check("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    n_total     = 0;
    n_pass      = 0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.pattern = '0;
    bus.len     = '0;
    bus.reps    = '0;
    bus.en      = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Directed cases from the test plan.
    run_xfer(8'b0000_0101, 4'd3, 4'd0, 100, -1);
    run_xfer(8'b0000_0101, 4'd3, 4'd2, 100, -1);
    run_xfer(8'b0000_0101, 4'd3, 4'd0, 100, 1);
    run_xfer(8'hA5, 4'd0, 4'd3, 100, -1);
    run_xfer(8'b1011_0010, 4'd15, 4'd0, 100, -1);
    run_xfer(8'hC3, 4'd8, 4'd1, 100, -1);

    // Asynchronous reset in the middle of a transfer.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.pattern = 8'hFF;
    bus.len     = 4'd8;
    bus.reps    = 4'd1;
    bus.en      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check_outs("pre_rst", 1'b1, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_outs("rst_async", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check_outs("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_outs("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    run_xfer(8'b0000_0110, 4'd3, 4'd1, 100, -1);

    // Randomized transfers with random stalls.
    for (int k = 0; k < 40; k++) begin
      run_xfer(8'($urandom), 4'($urandom_range(0, 15)),
               (k % 8 == 7) ? 4'd15 : 4'($urandom_range(0, 3)), 70, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/seq_generator.md
# seq_generator

Serial bit-pattern generator: the transmit-side counterpart of the team's serial sequence detector. It captures a programmable pattern word on `start` and emits it MSB-first, one bit per enabled cycle, on `dout`, with an optional repeat count. Its main uses are as bench and BIST stimulus for detector blocks, and as a framing or preamble source in front of serial links.

## Interface
Parameters:
- `WIDTH`, 8: maximum pattern length in bits (≥2).
- `REP_W`, 4: width of the repeat count.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request a transmission; sampled only in IDLE.
- `pattern`  in  WIDTH: pattern word; bits `[len-1:0]` are sent.
- `len`  in  $clog2(WIDTH+1): number of bits to send. 0 means nothing is sent. Any value >WIDTH is clamped to WIDTH.
- `reps`  in  REP_W: additional repetitions. Total passes = reps+1.
- `en`  in  1: advance enable. When low, the block stalls.
- `dout`  out  1: serial data.
- `dout_valid`  out  1: `dout` carries a pattern bit this cycle.
- `busy`  out  1: a transmission is in progress.
- `done`  out  1: one-cycle pulse when the transmission completes.

## Operation
- States: IDLE, SHIFT, GAP (GAP exists only with the macro enabled), DONE.
- **IDLE:**
  - All outputs are 0.
  - On `start`=1, capture `pattern`, clamped `len`, and `reps` into internal registers. Inputs may change afterwards without effect.
  - If the clamped len is 0, go to DONE. Otherwise load the shift register, set bit counter = len-1, set rep counter = reps, and go to SHIFT.
- **SHIFT:**
  - `dout` = `shreg[bitcnt]`, `dout_valid` = `en`, `busy` = 1.
  - With `en`=1:
    - If bitcnt > 0: decrement bitcnt.
    - Else if repcnt > 0: decrement repcnt and reload bitcnt = len-1. Go to GAP if `SEQ_GEN_GAP_EN` is defined, otherwise stay in SHIFT.
    - Else: go to DONE.
  - With `en`=0: state, counters and `dout` hold; `dout_valid` = 0.
- **GAP:**
  - `dout`=0, `dout_valid`=0, `busy`=1.
  - Go to SHIFT on the next cycle with `en`=1. Hold while `en`=0.
- **DONE:**
  - `done`=1 and `busy`=0 for exactly one cycle, then go to IDLE.
  - The DONE cycle ignores `en`.
- `start` is ignored in SHIFT, GAP and DONE. No queuing.
- All outputs are registered (Moore). They are driven from state and registers, never combinationally from inputs, except `dout_valid`, which is gated by `en`.

## Timing
- `start` sampled high at edge t → first bit (`pattern[len-1]`) on `dout` during cycle t+1.
- With `en` held high and no gap, bits appear in cycles t+1 … t+(reps+1)·len. `done` pulses in the following cycle.
- With the gap enabled, add one cycle per repetition: the last bit falls at t+(reps+1)·len+reps.
- len=0 → `done` in cycle t+1, `busy` never asserts, `dout_valid` never asserts.
- Each `en`=0 cycle in SHIFT or GAP delays all later events by exactly one cycle.
- A new `start` is accepted at the earliest in the cycle after `done`, i.e. the first IDLE cycle.
- Reset, asserted at any time including mid-pattern:
  - Immediate return to IDLE.
  - `dout`=0, `dout_valid`=0, `busy`=0, `done`=0.
  - Counters and shift register cleared.
  - No `done` is emitted for the aborted transfer.

## Configuration
- Macro: `SEQ_GEN_GAP_EN`.
- Defined: one idle cycle (`dout`=0, `dout_valid`=0, `busy`=1) is inserted between consecutive passes, so detectors resynchronise on a clean boundary.
- Undefined: the GAP state is not compiled. Passes are back-to-back with no dead cycle.

## Test plan
- pattern=8'b0000_0101, len=3, reps=0, `en`=1, start at t → `dout`=1,0,1 in t+1..t+3, `dout_valid`=1 in those cycles, `done` at t+4, `busy` low at t+4.
- pattern=3'b101, len=3, reps=2:
  - Without the macro → nine valid bits 101101101 in t+1..t+9, `done` at t+10.
  - With the macro → invalid gaps at t+4 and t+8, `done` at t+12.
- Same as the first case, with `en`=0 during t+2 → bit 0 held on `dout` with `dout_valid`=0 at t+2, then 0,1 at t+3, t+4, `done` at t+5.
- len=0 with start → `done` at t+1, `busy` and `dout_valid` stay 0. len=15 (WIDTH=8) → exactly 8 bits sent, MSB `pattern[7]` first.
- `start` pulsed with a different pattern at t+2 during a transfer → ignored, and the original bit stream is unchanged.
- `rst` asserted asynchronously mid-cycle at t+2 → all outputs 0 before the next edge, no `done`. After release, a fresh start transmits normally.
